// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the subtractive GCD controller and its datapath.
//   ctrlState_e : controller state encoding (3 bits)
//   SEL_*       : mux-select constants used by controller and datapath
//   flagsOneHot : true when exactly one of the gt/lt/eq flags is set
// ---------------------------------------------------------------------------
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    SUB_A  = 3'd4,
    SUB_B  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } ctrlState_e;

  // Subtractor operand muxes: pick register A or register B.
  localparam logic SEL_A    = 1'b0;
  localparam logic SEL_B    = 1'b1;
  // Bus mux: external data or subtractor result.
  localparam logic SEL_DATA = 1'b1;
  localparam logic SEL_SUB  = 1'b0;

  // A well-behaved comparator raises exactly one flag; anything else means
  // the datapath is broken or being driven from outside.
  function automatic logic flagsOneHot(input logic gt, input logic lt,
                                       input logic eq);
    return (gt ^ lt ^ eq) && !(gt && lt && eq);
  endfunction

endpackage

// File: rtl/gcd_if.sv
// ---------------------------------------------------------------------------
// gcd_if
// Control bundle between the GCD controller, its requester and the datapath.
//   start                 : run request from the requester
//   gt / lt / eq          : comparator flags from the datapath
//   ldA / ldB             : register load enables to the datapath
//   sel1 / sel2 / sel_in  : datapath mux selects
//   busy / done / err     : status back to the requester
// Modports:
//   master : controller side (drives enables, selects and status)
//   slave  : environment side (requester plus datapath)
// ---------------------------------------------------------------------------
interface gcd_if;

  logic start;
  logic gt;
  logic lt;
  logic eq;
  logic ldA;
  logic ldB;
  logic sel1;
  logic sel2;
  logic sel_in;
  logic busy;
  logic done;
  logic err;

  modport master (
    input  start, gt, lt, eq,
    output ldA, ldB, sel1, sel2, sel_in, busy, done, err
  );

  modport slave (
    output start, gt, lt, eq,
    input  ldA, ldB, sel1, sel2, sel_in, busy, done, err
  );

endinterface

// File: rtl/gcd_iter_cnt.sv
// ---------------------------------------------------------------------------
// gcd_iter_cnt
// Saturating iteration counter used as the GCD loop watchdog.
// Parameters:
//   MAX_ITER : saturation value (counter width is clog2(MAX_ITER+1))
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset, clears the count
//   clr_i    : clear the count (takes priority over inc_i)
//   inc_i    : advance the count by one unless already saturated
//   at_max_o : count has reached MAX_ITER
// ---------------------------------------------------------------------------
module gcd_iter_cnt #(
  parameter int MAX_ITER = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam int CntW = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_ITER);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  assign at_max_o = (count_q == CntMax);

  // Next count: clear wins, and once the count sits at MAX_ITER it stays
  // there so the watchdog condition can never wrap back to "not expired".
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !at_max_o) begin
      count_d = count_q + CntW'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gcd_controller.sv
// ---------------------------------------------------------------------------
// gcd_controller
// Control FSM for the 16-bit subtractive GCD datapath. Loads operand A then
// operand B from the bus, then alternates CHECK with SUB_A/SUB_B until the
// datapath reports A == B. A watchdog aborts runs that exceed MAX_ITER
// subtract steps (e.g. a zero operand), and illegal flag combinations abort
// immediately. All outputs are a pure decode of the state register.
// Parameters:
//   MAX_ITER : subtract steps allowed before the run ends in err
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, returns to IDLE from any state
//   ctrl  : gcd_if.master bundle (start/flags in; enables, selects, status out)
// ---------------------------------------------------------------------------
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = 65535
) (
  input  logic   clk,
  input  logic   rst_n,
  gcd_if.master  ctrl
);

  ctrlState_e state_q;
  ctrlState_e state_d;

  logic ldA;
  logic ldB;
  logic sel1;
  logic sel2;
  logic selIn;
  logic busy;
  logic done;
  logic err;
  logic cntClr;
  logic cntInc;
  logic atMax;

  // Watchdog: cleared at the start of every run, bumped once per subtract.
  gcd_iter_cnt #(
    .MAX_ITER (MAX_ITER)
  ) u_iterCnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cntClr),
    .inc_i    (cntInc),
    .at_max_o (atMax)
  );

  // State register; reset lands in IDLE even in the middle of a loop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode. Everything defaults to inactive so
  // each state only lists what it turns on. CHECK is kept as its own state
  // because the flags only reflect A and B one cycle after a load.
  always_comb begin
    state_d = state_q;
    ldA     = 1'b0;
    ldB     = 1'b0;
    sel1    = SEL_A;
    sel2    = SEL_A;
    selIn   = SEL_SUB;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    cntClr  = 1'b0;
    cntInc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl.start) begin
          state_d = LOAD_A;
        end
      end

      LOAD_A: begin
        busy    = 1'b1;
        selIn   = SEL_DATA;
        ldA     = 1'b1;
        cntClr  = 1'b1;
        state_d = LOAD_B;
      end

      LOAD_B: begin
        busy    = 1'b1;
        selIn   = SEL_DATA;
        ldB     = 1'b1;
        state_d = CHECK;
      end

      // Equality finishes even when the watchdog has saturated; otherwise an
      // expired watchdog beats another subtract.
      CHECK: begin
        busy = 1'b1;
        if (!flagsOneHot(ctrl.gt, ctrl.lt, ctrl.eq)) begin
          state_d = ERR;
        end else if (ctrl.eq) begin
          state_d = DONE;
        end else if (atMax) begin
          state_d = ERR;
        end else if (ctrl.gt) begin
          state_d = SUB_A;
        end else begin
          state_d = SUB_B;
        end
      end

      SUB_A: begin
        busy    = 1'b1;
        sel1    = SEL_A;
        sel2    = SEL_B;
        selIn   = SEL_SUB;
        ldA     = 1'b1;
        cntInc  = 1'b1;
        state_d = CHECK;
      end

      SUB_B: begin
        busy    = 1'b1;
        sel1    = SEL_B;
        sel2    = SEL_A;
        selIn   = SEL_SUB;
        ldB     = 1'b1;
        cntInc  = 1'b1;
        state_d = CHECK;
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      ERR: begin
        busy    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ctrl.ldA    = ldA;
  assign ctrl.ldB    = ldB;
  assign ctrl.sel1   = sel1;
  assign ctrl.sel2   = sel2;
  assign ctrl.sel_in = selIn;
  assign ctrl.busy   = busy;
  assign ctrl.done   = done;
  assign ctrl.err    = err;

endmodule

// File: tb/tb_gcd_controller.sv
// ---------------------------------------------------------------------------
// tb_gcd_controller
// Drives gcd_controller (MAX_ITER = 8) wired to a behavioural 16-bit
// subtractive datapath. Each run pushes its expected outcome (result, cycle
// of done/err, kind) onto a queue; a negedge monitor pops an entry whenever
// done or err is seen and compares.
// Output vector order: {ldA, ldB, sel1, sel2, sel_in, busy, done, err}.
// ---------------------------------------------------------------------------
module tb_gcd_controller;
  import gcd_pkg::*;

  localparam int MAXI = 8;

  typedef struct {
    logic [15:0] res;
    int          cyc;
    bit          isErr;
    int          startNeg;
  } expect_t;

  logic clk;
  logic rstN;
  logic [15:0] opA;
  logic [15:0] opB;
  logic [15:0] regA;
  logic [15:0] regB;
  logic [15:0] dataIn;
  logic [15:0] subOut;
  logic [15:0] busVal;
  logic        forceIllegal;
  logic [7:0]  outVec;

  int checks;
  int errors;
  int negCnt;
  expect_t sbQ[$];

  gcd_if ifc ();

  gcd_controller #(
    .MAX_ITER (MAXI)
  ) dut (
    .clk   (clk),
    .rst_n (rstN),
    .ctrl  (ifc.master)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: upstream presents A while ldA is high, else B.
  assign dataIn = ifc.ldA ? opA : opB;
  assign subOut = ((ifc.sel1 == SEL_B) ? regB : regA)
                - ((ifc.sel2 == SEL_B) ? regB : regA);
  assign busVal = (ifc.sel_in == SEL_DATA) ? dataIn : subOut;

  always @(posedge clk) begin
    if (ifc.ldA) regA <= busVal;
    if (ifc.ldB) regB <= busVal;
  end

  assign ifc.gt = forceIllegal ? 1'b1 : (regA > regB);
  assign ifc.lt = forceIllegal ? 1'b1 : (regA < regB);
  assign ifc.eq = forceIllegal ? 1'b0 : (regA == regB);

  assign outVec = {ifc.ldA, ifc.ldB, ifc.sel1, ifc.sel2, ifc.sel_in,
                   ifc.busy, ifc.done, ifc.err};

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference outcome from the subtractive algorithm: step count decides
  // timing, Euclid's remainder form gives the value.
  function automatic expect_t computeExpect(input logic [15:0] a,
                                            input logic [15:0] b);
    expect_t e;
    int k;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] t;
    e.isErr = 1'b0;
    e.startNeg = 0;
    k = 0;
    x = a;
    y = b;
    while (x != y && x != 0 && y != 0 && k <= MAXI) begin
      if (x > y) x = x - y;
      else       y = y - x;
      k++;
    end
    if (x != y || k > MAXI) begin
      e.isErr = 1'b1;
      e.cyc = 2 * MAXI + 4;
      e.res = 16'd0;
    end else begin
      e.cyc = 2 * k + 4;
      x = a;
      y = b;
      while (y != 0) begin
        t = x % y;
        x = y;
        y = t;
      end
      e.res = x;
    end
    return e;
  endfunction

  // Monitor: counts negedges and scores every done/err pulse.
  always @(negedge clk) begin
    expect_t e;
    negCnt = negCnt + 1;
    if (ifc.done || ifc.err) begin
      if (sbQ.size() == 0) begin
        checkOutput("spuriousPulse", {30'd0, ifc.done, ifc.err}, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("pulseKind", {31'd0, ifc.err}, {31'd0, e.isErr});
        checkOutput("pulseCycle", negCnt - e.startNeg, e.cyc);
        if (!e.isErr) begin
          checkOutput("resultA", regA, e.res);
          checkOutput("resultB", regB, e.res);
        end
      end
    end
  end

  // Waits until cycle n of a run whose start edge was recorded as s.
  task automatic waitCycle(input int s, input int n);
    while (negCnt - s < n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Starts a run, queues its expected outcome (errCyc > 0 forces an err
  // expectation at that cycle) and checks the two load cycles.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input bit keepStart, input int errCyc,
                               output int s);
    expect_t e;
    @(negedge clk);
    #1;
    opA = a;
    opB = b;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    if (!keepStart) ifc.start = 1'b0;
    s = negCnt;
    e = computeExpect(a, b);
    if (errCyc > 0) begin
      e.isErr = 1'b1;
      e.cyc = errCyc;
    end
    e.startNeg = s;
    sbQ.push_back(e);
    waitCycle(s, 1);
    checkOutput("loadA", outVec, 8'h8C);
    waitCycle(s, 2);
    checkOutput("loadB", outVec, 8'h4C);
  endtask

  // Bounded wait for all queued outcomes, then one idle cycle.
  task automatic drainAndIdle(input string tag);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "Drain"}, sbQ.size(), 0);
    sbQ.delete();
    @(negedge clk);
    #1;
    checkOutput({tag, "Idle"}, outVec, 8'h00);
  endtask

  initial begin
    int s;
    expect_t e2;
    checks = 0;
    errors = 0;
    negCnt = 0;
    forceIllegal = 1'b0;
    opA = 16'd0;
    opB = 16'd0;
    ifc.start = 1'b0;
    rstN = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetOutputs", outVec, 8'h00);
    rstN = 1'b1;

    // (48,18): CHECK, SUB_A, SUB_A, SUB_B, SUB_A; done in cycle 12 with 6.
    applyStimulus(16'd48, 16'd18, 1'b0, 0, s);
    waitCycle(s, 3);
    checkOutput("firstCheck", outVec, 8'h04);
    waitCycle(s, 4);
    checkOutput("subA", outVec, 8'h94);
    waitCycle(s, 8);
    checkOutput("subB", outVec, 8'h64);
    waitCycle(s, 12);
    checkOutput("doneVec", outVec, 8'h06);
    drainAndIdle("run48");

    // Equal operands: done in cycle 4.
    applyStimulus(16'd7, 16'd7, 1'b0, 0, s);
    drainAndIdle("run7");

    // Both zero: eq is set straight away, result 0.
    applyStimulus(16'd0, 16'd0, 1'b0, 0, s);
    drainAndIdle("run00");

    // Zero operand: watchdog err in cycle 20, done never.
    applyStimulus(16'd5, 16'd0, 1'b0, 0, s);
    waitCycle(s, 19);
    checkOutput("wdLastCheck", outVec, 8'h04);
    waitCycle(s, 20);
    checkOutput("wdErrVec", outVec, 8'h05);
    drainAndIdle("watchdog");

    // Extra start during the loop is ignored.
    applyStimulus(16'd48, 16'd18, 1'b0, 0, s);
    waitCycle(s, 5);
    ifc.start = 1'b1;
    waitCycle(s, 7);
    ifc.start = 1'b0;
    drainAndIdle("repulse");

    // start held through DONE: second LOAD_A two cycles after done.
    applyStimulus(16'd48, 16'd18, 1'b1, 0, s);
    e2 = computeExpect(16'd48, 16'd18);
    e2.startNeg = s + 13;
    sbQ.push_back(e2);
    waitCycle(s, 13);
    checkOutput("heldIdle", outVec, 8'h00);
    waitCycle(s, 14);
    checkOutput("heldLoadA", outVec, 8'h8C);
    ifc.start = 1'b0;
    drainAndIdle("held");

    // Reset during the third subtract, then a fresh (21,14) run.
    applyStimulus(16'd48, 16'd18, 1'b0, 0, s);
    waitCycle(s, 8);
    checkOutput("preResetSub", outVec, 8'h64);
    rstN = 1'b0;
    waitCycle(s, 9);
    checkOutput("midResetOutputs", outVec, 8'h00);
    sbQ.delete();
    rstN = 1'b1;
    waitCycle(s, 10);
    checkOutput("postResetIdle", outVec, 8'h00);
    applyStimulus(16'd21, 16'd14, 1'b0, 0, s);
    drainAndIdle("run21");

    // Illegal flags in CHECK: err in cycle 4, no loads in CHECK.
    forceIllegal = 1'b1;
    applyStimulus(16'd9, 16'd3, 1'b0, 4, s);
    waitCycle(s, 3);
    checkOutput("illegalCheck", outVec, 8'h04);
    drainAndIdle("illegal");
    forceIllegal = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Control FSM for the 16-bit subtractive GCD datapath. It sequences operand loading from `data_in`, runs the compare/subtract loop, and drives the datapath load enables and mux selects from the datapath's `gt`/`lt`/`eq` flags. It also provides a start/done handshake to the upstream requester and an iteration watchdog that flags non-terminating runs, such as a zero operand.

## Interface
Parameters:
- `MAX_ITER`, default 65535: maximum number of subtract steps before the run is aborted with `err`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: request a GCD run; sampled only in IDLE.
- `gt`, in, 1: datapath flag, A > B.
- `lt`, in, 1: datapath flag, A < B.
- `eq`, in, 1: datapath flag, A == B.
- `ldA`, out, 1: load register A from the bus.
- `ldB`, out, 1: load register B from the bus.
- `sel1`, out, 1: subtractor minuend mux; 0 = A, 1 = B.
- `sel2`, out, 1: subtractor subtrahend mux; 0 = A, 1 = B.
- `sel_in`, out, 1: bus mux; 1 = `data_in`, 0 = subtractor output.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse; the result is valid in register A (and in B).
- `err`, out, 1: one-cycle pulse; watchdog expired or the flags were illegal.

## Operation
- All outputs are Moore outputs (registered state decode). Any output not listed for a state is 0.
- States:
  - IDLE: `start`=1 → LOAD_A.
  - LOAD_A: `sel_in`=1, `ldA`=1. Upstream holds operand A on `data_in` this cycle. → LOAD_B.
  - LOAD_B: `sel_in`=1, `ldB`=1. Upstream holds operand B this cycle. → CHECK.
  - CHECK: no loads; flags are evaluated.
    - `eq` only → DONE.
    - `gt` only → SUB_A.
    - `lt` only → SUB_B.
    - Zero flags or more than one flag → ERR.
    - Iteration count == `MAX_ITER` with `eq`=0 → ERR. This condition takes priority over SUB_A and SUB_B.
  - SUB_A: `sel1`=0, `sel2`=1, `sel_in`=0, `ldA`=1, so A ← A−B. Iteration count +1. → CHECK.
  - SUB_B: `sel1`=1, `sel2`=0, `sel_in`=0, `ldB`=1, so B ← B−A. Iteration count +1. → CHECK.
  - DONE: `done`=1. → IDLE.
  - ERR: `err`=1. → IDLE.
- Iteration counter:
  - Width is clog2(`MAX_ITER`+1).
  - Cleared in LOAD_A.
  - Saturates at `MAX_ITER` and never wraps.
- `start` outside IDLE is ignored and is not queued.
- `start` held high across DONE/ERR immediately begins a new run: IDLE on one cycle, LOAD_A on the next.
- Reset (`rst_n`=0 at a clock edge) puts the FSM in IDLE from any state, including mid-loop, and clears the counter.
  - After reset, every output is 0.
  - Datapath register contents are don't-care.

## Timing
- Reference point: `start` sampled high in IDLE at edge 0. Cycle n is the cycle after edge n.
- LOAD_A occupies cycle 1, LOAD_B cycle 2, and the first CHECK cycle 3.
- Each subtract iteration costs 2 cycles (SUB, then CHECK).
- For k subtract steps:
  - `done` is high in cycle 2k+4.
  - `busy` is high in cycles 1 through 2k+4.
- Watchdog expiry: `err` is high in cycle 2·`MAX_ITER`+4.
- Flags are combinational from the registered A and B values. CHECK must not be merged with a load cycle.

## Structure
- Shared package `gcd_pkg` holds:
  - The state encoding: IDLE, LOAD_A, LOAD_B, CHECK, SUB_A, SUB_B, DONE, ERR, in 3 bits.
  - Mux-select constants: SEL_A=0, SEL_B=1, SEL_DATA=1, SEL_SUB=0. The datapath also uses these constants.
- One sub-module, `gcd_iter_cnt`: a saturating counter with `clr` and `inc` inputs and an `at_max` output, parameterised by `MAX_ITER`.
- Top-level integration instantiates `gcd_controller` alongside the existing datapath, with matching port names.

## Test plan
All scenarios run with the controller connected to the real datapath.
- Operands (48, 18): exactly 4 subtract steps; `done` pulses in cycle 12; A = B = 6; `err` stays 0.
- Operands (7, 7): no subtract steps; `done` in cycle 4; A = 7.
- `MAX_ITER`=8, operands (5, 0): 8 SUB_A cycles; `err` pulses in cycle 20; `done` never asserts; FSM returns to IDLE.
- Operands (48, 18) with `start` re-pulsed during the loop: the extra `start` is ignored and the result is unchanged. `start` held high through DONE: the second run's LOAD_A appears 2 cycles after `done`.
- `rst_n` driven low for 1 cycle during the third SUB of (48, 18): all outputs are 0 the next cycle, and the FSM is in IDLE. A fresh (21, 14) run then gives 7 with `done` in cycle 8.
- Forced `gt`=`lt`=1 in CHECK: `err` pulses in the next cycle, with no `ldA`/`ldB` asserted in between.
